// File: rtl/mem_delay_arbiter.sv
// mem_delay_arbiter: round-robin arbiter sharing one memory port between NUM_REQ requesters.
// A programmable number of stall cycles is inserted between arbitration and the memory
// request, so the trace/cache path can be studied under extra memory latency. Only one
// transaction is outstanding at a time.
// Optional: define MEM_DELAY_STATS_EN to add saturating stall_count_o / txn_count_o outputs.
module mem_delay_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DELAY_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    input  logic [DELAY_WIDTH-1:0]        delay_cycles_i,
    output logic                          mem_req_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic                          mem_we_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    output logic                          busy_o
`ifdef MEM_DELAY_STATS_EN
    ,
    output logic [31:0]                   stall_count_o,
    output logic [31:0]                   txn_count_o
`endif
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StIssue,
        StWaitR
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [DELAY_WIDTH-1:0]  counter_q, counter_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        cand_idx;
    int unsigned             cand;
    logic [IDX_W-1:0]        owner_next;

    // Per-requester views of the flattened address / write-data buses
    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: first set request scanning upward from rr_ptr, wrapping
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(rr_ptr_q) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_valid && req_i[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Next-state logic and combinational handshake outputs
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        counter_d = counter_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        mem_req_o = 1'b0;
        gnt_o     = '0;
        rvalid_o  = '0;
        rdata_o   = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d   = pick_idx;
                    addr_d    = addr_arr[pick_idx];
                    we_d      = we_i[pick_idx];
                    wdata_d   = wdata_arr[pick_idx];
                    counter_d = delay_cycles_i;
                    state_d   = (delay_cycles_i != '0) ? StDelay : StIssue;
                end
            end
            StDelay: begin
                // Loaded with D >= 1, so exactly D cycles are spent here and it never wraps
                counter_d = counter_q - 1'b1;
                if (counter_q == DELAY_WIDTH'(1)) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mem_req_o      = 1'b1;
                gnt_o[owner_q] = mem_gnt_i;
                if (mem_gnt_i) begin
                    state_d = StWaitR;
                end
            end
            StWaitR: begin
                rvalid_o[owner_q] = mem_rvalid_i;
                rdata_o           = mem_rdata_i;
                if (mem_rvalid_i) begin
                    rr_ptr_d = owner_next;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latched-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            counter_q <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            counter_q <= counter_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != StIdle);

`ifdef MEM_DELAY_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] txn_q;

    // Saturating counters of stall cycles and completed responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            txn_q   <= '0;
        end else begin
            if (state_q == StDelay && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
            if (state_q == StWaitR && mem_rvalid_i && txn_q != '1) begin
                txn_q <= txn_q + 1'b1;
            end
        end
    end

    assign stall_count_o = stall_q;
    assign txn_count_o   = txn_q;
`endif

endmodule

// File: tb/tb_mem_delay_arbiter.sv
// Bench for mem_delay_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and values.
module tb_mem_delay_arbiter;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DLW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_i = '0;
    logic [N*AW-1:0] addr_i = '0;
    logic [N-1:0]    we_i = '0;
    logic [N*DW-1:0] wdata_i = '0;
    logic [DLW-1:0]  delay_cycles_i = '0;
    logic            mem_gnt_i = 1'b0;
    logic            mem_rvalid_i = 1'b0;
    logic [DW-1:0]   mem_rdata_i = '0;
    logic [N-1:0]    gnt_o, rvalid_o;
    logic [DW-1:0]   rdata_o, mem_wdata_o;
    logic [AW-1:0]   mem_addr_o;
    logic            mem_req_o, mem_we_o, busy_o;
`ifdef MEM_DELAY_STATS_EN
    logic [31:0]     stall_count_o, txn_count_o;
`endif

    mem_delay_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DELAY_WIDTH(DLW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .delay_cycles_i(delay_cycles_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
`ifdef MEM_DELAY_STATS_EN
        , .stall_count_o(stall_count_o), .txn_count_o(txn_count_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (transaction level, time-stamped) ----------------
    int            m_cyc = 0;
    bit            m_active = 0;
    bit            m_granted = 0;
    int            m_owner = 0;
    int            m_rr = 0;
    int            m_issue_at = 0;
    logic [AW-1:0] m_addr = '0;
    logic          m_we = 1'b0;
    logic [DW-1:0] m_wdata = '0;
    logic [31:0]   m_stall = '0;
    logic [31:0]   m_txn = '0;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (p + i) % N;
            if (r[k]) return k;
        end
        return 0;
    endfunction

    function automatic logic exp_req_f();
        return m_active && !m_granted && (m_cyc >= m_issue_at);
    endfunction

    function automatic logic [N-1:0] oh_f();
        logic [N-1:0] one;
        one = 1;
        return one << m_owner;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active  <= 0;
            m_granted <= 0;
            m_rr      <= 0;
            m_stall   <= '0;
            m_txn     <= '0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (!m_active) begin
                if (req_i != '0) begin
                    m_active   <= 1;
                    m_granted  <= 0;
                    m_owner    <= rr_pick(req_i, m_rr);
                    m_addr     <= addr_i[rr_pick(req_i, m_rr)*AW +: AW];
                    m_we       <= we_i[rr_pick(req_i, m_rr)];
                    m_wdata    <= wdata_i[rr_pick(req_i, m_rr)*DW +: DW];
                    m_issue_at <= m_cyc + 1 + int'(delay_cycles_i);
                end
            end else if (!m_granted) begin
                if (m_cyc < m_issue_at) m_stall <= (m_stall == '1) ? m_stall : m_stall + 1;
                else if (mem_gnt_i) m_granted <= 1;
            end else if (mem_rvalid_i) begin
                m_active <= 0;
                m_rr     <= (m_owner + 1) % N;
                m_txn    <= (m_txn == '1) ? m_txn : m_txn + 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", busy_o, m_active);
        chk("mem_req", mem_req_o, exp_req_f());
        chk("gnt", gnt_o, (exp_req_f() && mem_gnt_i) ? oh_f() : '0);
        chk("rvalid", rvalid_o, (m_active && m_granted && mem_rvalid_i) ? oh_f() : '0);
        chk("rdata", rdata_o, (m_active && m_granted) ? mem_rdata_i : '0);
        if (exp_req_f()) begin
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_we", mem_we_o, m_we);
            chk("mem_wdata", mem_wdata_o, m_wdata);
        end
`ifdef MEM_DELAY_STATS_EN
        chk("stall_count", stall_count_o, m_stall);
        chk("txn_count", txn_count_o, m_txn);
`endif
    end

    // ---------------- memory responder ----------------
    int            gnt_cfg = 0;
    bit            force_rv = 0;
    logic [DW-1:0] rdata_cfg = '0;

    initial begin
        bit fire;
        bit prev;
        int cnt;
        prev = 0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            fire = mem_req_o && mem_gnt_i;
            @(posedge clk);
            #1;
            mem_rvalid_i = fire || force_rv;
            mem_rdata_i  = rdata_cfg;
            if (mem_req_o && !prev) cnt = gnt_cfg;
            if (mem_req_o) begin
                if (cnt > 0) begin
                    mem_gnt_i = 1'b0;
                    cnt--;
                end else begin
                    mem_gnt_i = 1'b1;
                end
            end else begin
                mem_gnt_i = 1'b0;
            end
            prev = mem_req_o;
        end
    end

    // ---------------- directed transactions ----------------
    int            r_lat, r_pulses, r_reqcyc;
    logic [DW-1:0] r_rd, r_wdata;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [N-1:0]  r_rv;

    task automatic run_txn(input int k, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [DLW-1:0] d,
                           input logic [DLW-1:0] d_after);
        bit seen;
        @(posedge clk);
        #1;
        req_i[k] = 1'b1;
        we_i[k] = we;
        addr_i[k*AW +: AW] = addr;
        wdata_i[k*DW +: DW] = wd;
        delay_cycles_i = d;
        r_lat = 0; r_pulses = 0; r_reqcyc = 0; r_rd = '0; r_rv = '0;
        r_addr = '0; r_we = 1'b0; r_wdata = '0;
        @(negedge clk);                // arbitration cycle
        @(posedge clk);
        #1;
        delay_cycles_i = d_after;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            r_lat++;
            if (mem_req_o) begin
                seen = 1;
                r_addr = mem_addr_o;
                r_we = mem_we_o;
                r_wdata = mem_wdata_o;
                break;
            end
        end
        chk("mem_req_seen", seen, 1);
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (mem_req_o) r_reqcyc++;
            if (gnt_o != '0) r_pulses++;
            if (rvalid_o != '0) begin
                r_rv = rvalid_o;
                r_rd = rdata_o;
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rvalid_seen", seen, 1);
        @(posedge clk);
        #1;
        req_i[k] = 1'b0;
    endtask

    int exp_order[4] = '{0, 1, 0, 1};
    int got_order[4];

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_mem_req", mem_req_o, 0);
        chk("reset_gnt", gnt_o, 0);
        #2 rst_n = 1'b1;

        // Reset asserted while sitting in ISSUE
        gnt_cfg = 1000;
        @(posedge clk);
        #1;
        req_i = 2'b01;
        addr_i[AW-1:0] = 32'h10;
        delay_cycles_i = '0;
        repeat (3) @(negedge clk);
        chk("issue_before_reset", mem_req_o, 1);
        #2 rst_n = 1'b0;
        req_i = '0;
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        gnt_cfg = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_txn(0, 1'b0, 32'h20, 32'h0, 8'd0, 8'd0);
        chk("lat_d0", r_lat, 1);

        // Delay injection D=5
        rdata_cfg = 32'hDEADBEEF;
        run_txn(0, 1'b0, 32'h100, 32'h0, 8'd5, 8'd5);
        chk("lat_d5", r_lat, 6);
        chk("d5_addr", r_addr, 32'h100);
        chk("d5_rvalid", r_rv, 2'b01);
        chk("d5_rdata", r_rd, 32'hDEADBEEF);

        // Back-pressure: grant withheld for 4 cycles
        gnt_cfg = 4;
        run_txn(1, 1'b0, 32'h200, 32'h0, 8'd0, 8'd0);
        gnt_cfg = 0;
        chk("bp_req_cycles", r_reqcyc, 5);
        chk("bp_gnt_pulses", r_pulses, 1);
        chk("bp_rvalid", r_rv, 2'b10);

        // Round-robin with both requests held
        @(posedge clk);
        #1;
        addr_i = {32'hB0, 32'hA0};
        delay_cycles_i = '0;
        req_i = 2'b11;
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge clk);
            if (gnt_o != '0) begin
                got_order[n] = gnt_o[1] ? 1 : 0;
                n++;
            end
        end
        @(posedge clk);
        #1;
        req_i = '0;
        chk("rr_count", n, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), got_order[i], exp_order[i]);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy_o) break;
        end
        chk("rr_idle", busy_o, 0);

        // Config change mid-transaction; spurious rvalid outside WAIT_R is ignored
        force_rv = 1;
        run_txn(0, 1'b0, 32'h300, 32'h0, 8'd3, 8'd10);
        force_rv = 0;
        chk("cfg_lat_3", r_lat, 4);
        run_txn(0, 1'b0, 32'h304, 32'h0, 8'd10, 8'd10);
        chk("cfg_lat_10", r_lat, 11);

        // Fresh reset, then write with maximum delay
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_txn(1, 1'b1, 32'h40, 32'h55, 8'd255, 8'd255);
        chk("max_lat", r_lat, 256);
        chk("max_we", r_we, 1);
        chk("max_wdata", r_wdata, 32'h55);
        chk("max_addr", r_addr, 32'h40);
        chk("max_rvalid", r_rv, 2'b10);
`ifdef MEM_DELAY_STATS_EN
        chk("stats_stall", stall_count_o, 255);
        chk("stats_txn", txn_count_o, 1);
`endif
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

endmodule
